fp_to_int: RTL and testbench
============================

FP_TO_INT -- requirements
Module: fp_to_int

Interface
REQ-001 SHALL provide parameter: none; the block is fixed at 32-bit input and output.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  opd and is_signed are valid this cycle.
REQ-005 SHALL have port: in_ready  output  1  block accepts the input this cycle.
REQ-006 SHALL have port: opd  input  32  IEEE-754 binary32 operand.
REQ-007 SHALL have port: is_signed  input  1  1 = convert to int32, 0 = convert to uint32.
REQ-008 SHALL have port: out_valid  output  1  res and flags are valid.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts the output this cycle.
REQ-010 SHALL have port: res  output  32  integer result.
REQ-011 SHALL have ports: nan, overflow, inexact  output  1 each  exception flags qualified by out_valid.

Function
REQ-012 SHALL be a 3-stage elastic pipeline: unpack/classify, align shift, round/saturate.
REQ-013 SHALL compute advance = !out_valid | out_ready, drive in_ready = advance, and stall all stages together when advance = 0.
REQ-014 SHALL accept a transfer only when in_valid & in_ready, and SHALL retire an output only when out_valid & out_ready.
REQ-015 SHALL have latency 3 cycles from accept to out_valid with no stall, and throughput 1 per cycle.
REQ-016 SHALL keep res and flags stable while out_valid = 1 and out_ready = 0.
REQ-017 SHALL preserve results in order, with no loss or duplication under any in_valid/out_ready pattern.
REQ-018 SHALL compute unbiased exponent e = exp - 127 with significand {1,mant}; exp = 0 (zero or denormal) SHALL give magnitude 0 and inexact = (mant != 0).
REQ-019 SHALL form the magnitude by shifting the 24-bit significand by e-23; bits shifted out SHALL form the guard bit and the sticky bit (OR of the rest).
REQ-020 SHALL, for e >= 32, saturate the result and set overflow.
REQ-021 SHALL, when is_signed = 1, saturate a positive magnitude > 2^31-1 to 0x7FFFFFFF and a negative magnitude > 2^31 to 0x80000000, both with overflow; -2^31 SHALL convert exactly.
REQ-022 SHALL, when is_signed = 0, saturate a magnitude > 2^32-1 to 0xFFFFFFFF with overflow; a negative input whose rounded magnitude is nonzero SHALL give 0 with overflow, and one whose rounded magnitude is 0 SHALL give 0 with inexact.
REQ-023 SHALL treat NaN (exp = 255, mant != 0) as res = 0x7FFFFFFF (signed) or 0xFFFFFFFF (unsigned), with nan = 1, overflow = 0, inexact = 0.
REQ-024 SHALL treat infinity as saturation per sign and is_signed, with overflow = 1.
REQ-025 SHALL assert inexact = 1 only when guard|sticky != 0 and neither nan nor overflow is set; nan and overflow SHALL be mutually exclusive.
REQ-026 SHALL apply rounding before the range check, so a carry out of rounding that exceeds the range SHALL saturate.

Reset
REQ-027 SHALL, with rst = 1 at a clock edge, clear all stage valid bits, res, nan, overflow, and inexact to 0 in that cycle; in_ready SHALL be 1 in the first cycle after reset.
REQ-028 SHALL discard any operation in flight when reset is asserted; none of them SHALL be emitted after reset.
REQ-029 SHALL ignore in_valid while rst = 1.

Configuration
REQ-030 SHALL, with macro FP_TO_INT_ROUND_NEAREST_EN defined, round to nearest, ties to even: increment when guard & (sticky | lsb).
REQ-031 SHALL, without the macro, truncate toward zero (discard guard and sticky); inexact SHALL still report nonzero discarded bits; latency SHALL be unchanged.

Verification
REQ-032 SHALL cover: opd = 0x3FC00000 (1.5), is_signed = 1 -> macro defined: res = 2, inexact = 1; macro undefined: res = 1, inexact = 1.
REQ-033 SHALL cover: opd = 0x40200000 (2.5) -> res = 2, inexact = 1 (RNE); opd = 0x3F000000 (0.5) -> res = 0, inexact = 1.
REQ-034 SHALL cover: opd = 0xCF000000, is_signed = 1 -> res = 0x80000000, no flags; opd = 0x4F000000 -> signed: res = 0x7FFFFFFF, overflow = 1; unsigned: res = 0x80000000, no flags.
REQ-035 SHALL cover: opd = 0x7FC00000 -> res = 0x7FFFFFFF, nan = 1 (signed); opd = 0xFF800000 unsigned -> res = 0, overflow = 1.
REQ-036 SHALL cover: 5 back-to-back inputs with out_ready = 0 for cycles 2-7 -> in_ready drops once 3 results are held, all 5 results emerge in order, and held outputs stay stable.
REQ-037 SHALL cover: rst pulsed for 1 cycle with 2 operations in flight -> out_valid = 0 the next cycle and no stale result is emitted.

Source files
------------

// File: rtl/fp_to_int.sv
// fp_to_int: IEEE-754 binary32 to int32/uint32 converter.
// The converter is a 3-stage elastic pipeline:
//   stage 1 unpacks and classifies the operand,
//   stage 2 aligns the significand and extracts the guard and sticky bits,
//   stage 3 rounds, checks the range, saturates and raises the flags.
// All three stages stall together whenever a result is held at the output.
// Optional feature: define FP_TO_INT_ROUND_NEAREST_EN to round to nearest, ties
// to even. Without it the converter truncates toward zero. Latency is the same
// in both builds.
module fp_to_int (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] opd,
  input  logic        is_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res,
  output logic        nan,
  output logic        overflow,
  output logic        inexact
);

  logic        advance;

  // Stage valid bits and the registered outputs. Only these are reset.
  logic        s1Valid_q, s2Valid_q, s3Valid_q;
  logic [31:0] res_q, res_d;
  logic        nan_q, nan_d;
  logic        ovf_q, ovf_d;
  logic        inx_q, inx_d;

  // Stage 1 payload: the operand fields plus their classification.
  logic        s1Sign_q, s1Sign_d;
  logic        s1Signed_q, s1Signed_d;
  logic        s1Nan_q, s1Nan_d;
  logic        s1Big_q, s1Big_d;
  logic [7:0]  s1Exp_q, s1Exp_d;
  logic [23:0] s1Sig_q, s1Sig_d;

  // Stage 2 payload: the aligned integer magnitude and the bits shifted out.
  logic        s2Sign_q;
  logic        s2Signed_q;
  logic        s2Nan_q;
  logic        s2Big_q;
  logic [31:0] s2Mag_q, s2Mag_d;
  logic        s2Guard_q, s2Guard_d;
  logic        s2Sticky_q, s2Sticky_d;

  // Working signals for stages 2 and 3.
  logic [7:0]  leftShift, rightShift;
  logic [49:0] wide;
  logic        inc;
  logic [32:0] rounded;
  logic        lostBits;

  // The whole pipeline moves only when the output slot is free or is being drained.
  assign advance   = !s3Valid_q | out_ready;
  assign in_ready  = advance;
  assign out_valid = s3Valid_q;
  assign res       = res_q;
  assign nan       = nan_q;
  assign overflow  = ovf_q;
  assign inexact   = inx_q;

  // Stage 1: split the operand into fields and classify NaN and too-large values.
  always_comb begin
    s1Sign_d   = opd[31];
    s1Signed_d = is_signed;
    s1Exp_d    = opd[30:23];
    s1Sig_d    = {(opd[30:23] != 8'd0), opd[22:0]};
    s1Nan_d    = (opd[30:23] == 8'hFF) && (opd[22:0] != 23'd0);
    // Biased exponent 159 is an unbiased exponent of 32; from there on, and for
    // infinity, the value cannot fit in 32 bits.
    s1Big_d    = (opd[30:23] >= 8'd159) && !s1Nan_d;
  end

  // Stage 2: shift the 24-bit significand by e-23 (biased exponent minus 150).
  always_comb begin
    leftShift  = s1Exp_q - 8'd150;
    rightShift = 8'd150 - s1Exp_q;
    wide       = '0;
    s2Mag_d    = '0;
    s2Guard_d  = 1'b0;
    s2Sticky_d = 1'b0;
    if (s1Exp_q == 8'd0) begin
      // Zero and denormals have magnitude 0; any mantissa bit is lost precision.
      s2Sticky_d = |s1Sig_q[22:0];
    end else if (s1Nan_q || s1Big_q) begin
      s2Sticky_d = 1'b0;
    end else if (s1Exp_q >= 8'd150) begin
      s2Mag_d = {8'd0, s1Sig_q} << leftShift;
    end else if (rightShift > 8'd25) begin
      // Value is below 0.25: guard is 0 and the nonzero significand is all sticky.
      s2Sticky_d = 1'b1;
    end else begin
      wide       = {s1Sig_q, 26'd0} >> rightShift;
      s2Mag_d    = {8'd0, wide[49:26]};
      s2Guard_d  = wide[25];
      s2Sticky_d = |wide[24:0];
    end
  end

  // Stage 3: round the magnitude first, then range-check and saturate.
  always_comb begin
`ifdef FP_TO_INT_ROUND_NEAREST_EN
    inc = s2Guard_q & (s2Sticky_q | s2Mag_q[0]);
`else
    inc = 1'b0;
`endif
    rounded  = {1'b0, s2Mag_q} + {32'd0, inc};
    lostBits = s2Guard_q | s2Sticky_q;
    res_d    = rounded[31:0];
    nan_d    = 1'b0;
    ovf_d    = 1'b0;
    if (s2Nan_q) begin
      nan_d = 1'b1;
      res_d = s2Signed_q ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
    end else if (s2Big_q) begin
      ovf_d = 1'b1;
      if (s2Signed_q) res_d = s2Sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
      else            res_d = s2Sign_q ? 32'h0000_0000 : 32'hFFFF_FFFF;
    end else if (s2Signed_q) begin
      if (!s2Sign_q) begin
        if (rounded > 33'h0_7FFF_FFFF) begin
          ovf_d = 1'b1;
          res_d = 32'h7FFF_FFFF;
        end
      end else if (rounded > 33'h0_8000_0000) begin
        ovf_d = 1'b1;
        res_d = 32'h8000_0000;
      end else begin
        res_d = 32'd0 - rounded[31:0];
      end
    end else begin
      if (!s2Sign_q) begin
        if (rounded[32]) begin
          ovf_d = 1'b1;
          res_d = 32'hFFFF_FFFF;
        end
      end else begin
        // Negative inputs can never be represented; only a zero rounded
        // magnitude escapes the overflow flag.
        ovf_d = (rounded != 33'd0);
        res_d = 32'd0;
      end
    end
    inx_d = lostBits & !nan_d & !ovf_d;
  end

  // Control path: valid bits and output registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      s2Valid_q <= 1'b0;
      s3Valid_q <= 1'b0;
      res_q     <= '0;
      nan_q     <= 1'b0;
      ovf_q     <= 1'b0;
      inx_q     <= 1'b0;
    end else if (advance) begin
      s1Valid_q <= in_valid;
      s2Valid_q <= s1Valid_q;
      s3Valid_q <= s2Valid_q;
      res_q     <= res_d;
      nan_q     <= nan_d;
      ovf_q     <= ovf_d;
      inx_q     <= inx_d;
    end
  end

  // Data path: payload registers follow the valid bits and need no reset.
  always_ff @(posedge clk) begin
    if (advance) begin
      s1Sign_q   <= s1Sign_d;
      s1Signed_q <= s1Signed_d;
      s1Nan_q    <= s1Nan_d;
      s1Big_q    <= s1Big_d;
      s1Exp_q    <= s1Exp_d;
      s1Sig_q    <= s1Sig_d;
      s2Sign_q   <= s1Sign_q;
      s2Signed_q <= s1Signed_q;
      s2Nan_q    <= s1Nan_q;
      s2Big_q    <= s1Big_q;
      s2Mag_q    <= s2Mag_d;
      s2Guard_q  <= s2Guard_d;
      s2Sticky_q <= s2Sticky_d;
    end
  end

endmodule

// File: tb/tb_fp_to_int.sv
// tb_fp_to_int: self-checking bench for fp_to_int.
// Expected results come from an exact fixed-point model of the float value,
// honouring FP_TO_INT_ROUND_NEAREST_EN the same way the design does.
module tb_fp_to_int;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] opd;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic        nan;
  logic        overflow;
  logic        inexact;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] opd;
    logic        sgn;
    logic [34:0] exp;
  } vec_t;

  fp_to_int dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opd       (opd),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .nan       (nan),
    .overflow  (overflow),
    .inexact   (inexact)
  );

  always #5 clk = ~clk;

  // Reference: scale the operand value by 2^150 so it becomes an exact integer,
  // split integer and fraction, round, then range-check. Returns {res,nan,ovf,inx}.
  function automatic logic [34:0] refConvert(input logic [31:0] f, input logic sgn);
    logic [7:0]   ex;
    logic [22:0]  mt;
    logic         neg;
    logic [319:0] val, ip, frac, fracMask;
    logic [31:0]  r;
    logic         ovf, inx0;
`ifdef FP_TO_INT_ROUND_NEAREST_EN
    logic [319:0] half;
`endif
    ex  = f[30:23];
    mt  = f[22:0];
    neg = f[31];
    if (ex == 8'hFF && mt != 23'd0) return {(sgn ? 32'h7FFF_FFFF : 32'hFFFF_FFFF), 3'b100};
    if (ex == 8'hFF) begin
      if (sgn) r = neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
      else     r = neg ? 32'h0 : 32'hFFFF_FFFF;
      return {r, 3'b010};
    end
    if (ex == 8'd0) val = {297'd0, mt} << 1;
    else            val = {296'd0, 1'b1, mt} << ex;
    ip       = val >> 150;
    fracMask = (320'd1 << 150) - 320'd1;
    frac     = val & fracMask;
    inx0     = (frac != 320'd0);
`ifdef FP_TO_INT_ROUND_NEAREST_EN
    half = 320'd1 << 149;
    if (frac > half || (frac == half && ip[0])) ip = ip + 320'd1;
`endif
    ovf = 1'b0;
    r   = 32'd0;
    if (sgn) begin
      if (!neg) begin
        if (ip > 320'h7FFF_FFFF) begin r = 32'h7FFF_FFFF; ovf = 1'b1; end
        else r = ip[31:0];
      end else begin
        if (ip > 320'h8000_0000) begin r = 32'h8000_0000; ovf = 1'b1; end
        else r = 32'd0 - ip[31:0];
      end
    end else begin
      if (!neg) begin
        if (ip > 320'hFFFF_FFFF) begin r = 32'hFFFF_FFFF; ovf = 1'b1; end
        else r = ip[31:0];
      end else begin
        ovf = (ip != 320'd0);
        r   = 32'd0;
      end
    end
    return {r, 1'b0, ovf, inx0 & !ovf};
  endfunction

  // Operand generator biased toward exponents near the integer range.
  function automatic logic [31:0] randOpd();
    int          pick;
    logic [7:0]  ex;
    logic [22:0] mt;
    pick = $urandom_range(0, 9);
    mt   = 23'($urandom);
    if (pick == 0)      ex = 8'd0;
    else if (pick == 1) ex = 8'hFF;
    else if (pick <= 3) ex = 8'($urandom_range(0, 255));
    else                ex = 8'($urandom_range(100, 165));
    if ($urandom_range(0, 3) == 0) mt[19:0] = 20'd0;
    if (pick == 1 && $urandom_range(0, 1) == 0) mt = 23'd0;
    return {1'($urandom_range(0, 1)), ex, mt};
  endfunction

  // Send one operand into an empty pipeline and wait for its result.
  task automatic sendOne(input logic [31:0] f, input logic sgn,
                         output logic [34:0] got, output int lat);
    @(posedge clk); #1;
    in_valid  = 1'b1;
    opd       = f;
    is_signed = sgn;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    got = 'x;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid === 1'b1) begin
        got = {res, nan, overflow, inexact};
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    opd       = 32'h3F80_0000;
    is_signed = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, res, nan, overflow, inexact} !== 36'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got valid=%b res=%h flags=%b%b%b, want all 0",
               out_valid, res, nan, overflow, inexact);
    end
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    // Operations presented during reset must never surface.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_ignore: got out_valid=%b at cycle %0d, want 0", out_valid, i);
      end
    end
  endtask

  task automatic test_directed();
    vec_t        vecs[$];
    vec_t        v;
    logic [34:0] got;
    int          lat;
`ifdef FP_TO_INT_ROUND_NEAREST_EN
    v = '{32'h3FC0_0000, 1'b1, {32'd2, 3'b001}};          vecs.push_back(v);
    v = '{32'hBF40_0000, 1'b0, {32'd0, 3'b010}};          vecs.push_back(v);
    v = '{32'h3FE0_0000, 1'b1, {32'd2, 3'b001}};          vecs.push_back(v);
`else
    v = '{32'h3FC0_0000, 1'b1, {32'd1, 3'b001}};          vecs.push_back(v);
    v = '{32'hBF40_0000, 1'b0, {32'd0, 3'b001}};          vecs.push_back(v);
    v = '{32'h3FE0_0000, 1'b1, {32'd1, 3'b001}};          vecs.push_back(v);
`endif
    v = '{32'h4020_0000, 1'b1, {32'd2, 3'b001}};          vecs.push_back(v);
    v = '{32'h3F00_0000, 1'b1, {32'd0, 3'b001}};          vecs.push_back(v);
    v = '{32'hCF00_0000, 1'b1, {32'h8000_0000, 3'b000}};  vecs.push_back(v);
    v = '{32'h4F00_0000, 1'b1, {32'h7FFF_FFFF, 3'b010}};  vecs.push_back(v);
    v = '{32'h4F00_0000, 1'b0, {32'h8000_0000, 3'b000}};  vecs.push_back(v);
    v = '{32'h7FC0_0000, 1'b1, {32'h7FFF_FFFF, 3'b100}};  vecs.push_back(v);
    v = '{32'h7FC0_0000, 1'b0, {32'hFFFF_FFFF, 3'b100}};  vecs.push_back(v);
    v = '{32'hFF80_0000, 1'b0, {32'h0, 3'b010}};          vecs.push_back(v);
    v = '{32'h7F80_0000, 1'b1, {32'h7FFF_FFFF, 3'b010}};  vecs.push_back(v);
    v = '{32'hBF00_0000, 1'b0, {32'h0, 3'b001}};          vecs.push_back(v);
    v = '{32'h4F80_0000, 1'b0, {32'hFFFF_FFFF, 3'b010}};  vecs.push_back(v);
    v = '{32'h0000_0001, 1'b1, {32'h0, 3'b001}};          vecs.push_back(v);
    v = '{32'h8000_0000, 1'b1, {32'h0, 3'b000}};          vecs.push_back(v);
    v = '{32'h3F80_0000, 1'b1, {32'd1, 3'b000}};          vecs.push_back(v);
    v = '{32'hC020_0000, 1'b1, {32'hFFFF_FFFE, 3'b001}};  vecs.push_back(v);
    v = '{32'hCF00_0001, 1'b1, {32'h8000_0000, 3'b010}};  vecs.push_back(v);
    foreach (vecs[i]) begin
      sendOne(vecs[i].opd, vecs[i].sgn, got, lat);
      checks++;
      if (got !== vecs[i].exp) begin
        errors++;
        $display("[TB] FAIL directed_%h_s%0d: got res=%h nan/ovf/inx=%b, want res=%h nan/ovf/inx=%b",
                 vecs[i].opd, vecs[i].sgn, got[34:3], got[2:0], vecs[i].exp[34:3], vecs[i].exp[2:0]);
      end
      checks++;
      if (lat != 3) begin
        errors++;
        $display("[TB] FAIL latency_%h: got %0d cycles, want 3", vecs[i].opd, lat);
      end
    end
  endtask

  task automatic test_random();
    logic [34:0] expQ[$];
    logic [34:0] held, want;
    logic        holdPending;
    holdPending = 1'b0;
    held        = '0;
    for (int cyc = 0; cyc < 640; cyc++) begin
      @(posedge clk); #1;
      if (cyc < 600) begin
        in_valid  = ($urandom_range(0, 9) < 7);
        opd       = randOpd();
        is_signed = 1'($urandom_range(0, 1));
        out_ready = ($urandom_range(0, 9) < 6);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (holdPending) begin
        checks++;
        if (out_valid !== 1'b1 || {res, nan, overflow, inexact} !== held) begin
          errors++;
          $display("[TB] FAIL random_hold: got valid=%b res=%h flags=%b, want valid=1 res=%h flags=%b",
                   out_valid, res, {nan, overflow, inexact}, held[34:3], held[2:0]);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL random_extra: got unexpected res=%h, want no output", res);
        end else begin
          want = expQ.pop_front();
          if ({res, nan, overflow, inexact} !== want) begin
            errors++;
            $display("[TB] FAIL random_result: got res=%h flags=%b, want res=%h flags=%b",
                     res, {nan, overflow, inexact}, want[34:3], want[2:0]);
          end
        end
      end
      holdPending = (out_valid === 1'b1) && !out_ready;
      held        = {res, nan, overflow, inexact};
      if (in_valid && in_ready === 1'b1) expQ.push_back(refConvert(opd, is_signed));
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL random_drain: got %0d results missing, want 0", expQ.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ops[5];
    logic [34:0] expQ[$];
    logic [34:0] want, held;
    logic        holdPending, sawDrop;
    int          sent, got;
    ops[0] = 32'h3FC0_0000;
    ops[1] = 32'hCF00_0000;
    ops[2] = 32'h4020_0000;
    ops[3] = randOpd();
    ops[4] = 32'h7FC0_0000;
    sent = 0;
    got = 0;
    sawDrop = 1'b0;
    holdPending = 1'b0;
    held = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      in_valid  = (sent < 5);
      opd       = ops[(sent < 5) ? sent : 4];
      is_signed = 1'b1;
      out_ready = !(c >= 2 && c <= 7);
      @(negedge clk);
      if (holdPending) begin
        checks++;
        if (out_valid !== 1'b1 || {res, nan, overflow, inexact} !== held) begin
          errors++;
          $display("[TB] FAIL b2b_hold: got res=%h flags=%b at cycle %0d, want res=%h flags=%b",
                   res, {nan, overflow, inexact}, c, held[34:3], held[2:0]);
        end
      end
      if (in_ready === 1'b0 && !sawDrop) begin
        sawDrop = 1'b1;
        checks++;
        if (sent - got != 3) begin
          errors++;
          $display("[TB] FAIL b2b_drop: got in_ready=0 with %0d held, want 3 held", sent - got);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        want = (expQ.size() != 0) ? expQ.pop_front() : 35'h0;
        if ({res, nan, overflow, inexact} !== want) begin
          errors++;
          $display("[TB] FAIL b2b_order_%0d: got res=%h flags=%b, want res=%h flags=%b",
                   got, res, {nan, overflow, inexact}, want[34:3], want[2:0]);
        end
        got++;
      end
      holdPending = (out_valid === 1'b1) && !out_ready;
      held        = {res, nan, overflow, inexact};
      if (in_valid && in_ready === 1'b1) begin
        expQ.push_back(refConvert(opd, 1'b1));
        sent++;
      end
    end
    checks++;
    if (!sawDrop || got != 5) begin
      errors++;
      $display("[TB] FAIL b2b_count: got drop=%b results=%0d, want drop=1 results=5", sawDrop, got);
    end
  endtask

  task automatic test_reset_flush();
    int          stray;
    logic [34:0] gotR;
    int          lat;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      in_valid  = (c <= 2);
      opd       = 32'h4110_0000;
      is_signed = 1'b1;
      out_ready = 1'b1;
      rst       = (c == 3);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_next: got out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("[TB] FAIL flush_stale: got %0d stale outputs, want 0", stray);
    end
    sendOne(32'h4110_0000, 1'b1, gotR, lat);
    checks++;
    if (gotR !== {32'd9, 3'b000}) begin
      errors++;
      $display("[TB] FAIL flush_resume: got res=%h flags=%b, want res=00000009 flags=000",
               gotR[34:3], gotR[2:0]);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    opd       = '0;
    is_signed = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
